hazard_ctrl: RTL and testbench

Parametrised ID-stage hazard unit for the MIPS pipeline. It generalises the fixed EX/MEM stall generator to NSTG downstream write stages, with optional forwarding-select generation and load-use detection. It drives the PC/IF-ID hold, the ID/EX bubble and the operand forwarding muxes. A counter holds multi-cycle stalls deterministically, and the block keeps a saturating stall-cycle statistic.

---
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard bus: register read requests and downstream write-stage status in,
// pipeline hold/bubble/forward controls out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int NSTG   = 3,
  parameter int CNT_W  = 2,
  parameter int STAT_W = 16
);
  localparam int FWD_W = $clog2(NSTG + 1);

  logic [REG_AW-1:0]      in_rs_addr;
  logic [REG_AW-1:0]      in_rt_addr;
  logic                   in_rs_rena;
  logic                   in_rt_rena;
  logic [NSTG-1:0]        in_stg_wena;
  logic [NSTG*REG_AW-1:0] in_stg_waddr;
  logic [NSTG-1:0]        in_stg_rdy;
  logic                   in_flush;

  logic                   out_stall;
  logic                   out_bubble;
  logic [FWD_W-1:0]       out_fwd_rs;
  logic [FWD_W-1:0]       out_fwd_rt;
  logic [CNT_W-1:0]       out_stall_cnt;
  logic [STAT_W-1:0]      out_stall_total;

  modport master (
    output in_rs_addr, in_rt_addr, in_rs_rena, in_rt_rena,
           in_stg_wena, in_stg_waddr, in_stg_rdy, in_flush,
    input  out_stall, out_bubble, out_fwd_rs, out_fwd_rt,
           out_stall_cnt, out_stall_total
  );

  modport slave (
    input  in_rs_addr, in_rt_addr, in_rs_rena, in_rt_rena,
           in_stg_wena, in_stg_waddr, in_stg_rdy, in_flush,
    output out_stall, out_bubble, out_fwd_rs, out_fwd_rt,
           out_stall_cnt, out_stall_total
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Parametrised ID-stage hazard unit: detects RAW hazards against NSTG write stages,
// generates stall/bubble (counter-held multi-cycle stalls) and operand forwarding selects.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int NSTG   = 3,
  parameter int FWD_EN = 0,
  parameter int CNT_W  = 2,
  parameter int STAT_W = 16
) (
  input  logic          in_clk,
  input  logic          in_rst,
  hazard_ctrl_if.slave  bus
);

  localparam int FWD_W = $clog2(NSTG + 1);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    IDLE  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAT_W-1:0] total_q, total_d;

  logic              rs_hit, rt_hit;
  logic              rs_rdy, rt_rdy;
  logic [FWD_W-1:0]  rs_k, rt_k, kmin;
  logic [CNT_W-1:0]  extra;

  logic              stall, bubble;
  logic [FWD_W-1:0]  fwd_rs, fwd_rt;

  // Scan oldest to youngest so the lowest matching stage is the one that sticks.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    rs_rdy = 1'b0;
    rt_rdy = 1'b0;
    rs_k   = '0;
    rt_k   = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (bus.in_stg_wena[k] && bus.in_rs_rena && (bus.in_rs_addr != '0) &&
          (bus.in_stg_waddr[k*REG_AW +: REG_AW] == bus.in_rs_addr)) begin
        rs_hit = 1'b1;
        rs_k   = FWD_W'(k);
        rs_rdy = bus.in_stg_rdy[k];
      end
      if (bus.in_stg_wena[k] && bus.in_rt_rena && (bus.in_rt_addr != '0) &&
          (bus.in_stg_waddr[k*REG_AW +: REG_AW] == bus.in_rt_addr)) begin
        rt_hit = 1'b1;
        rt_k   = FWD_W'(k);
        rt_rdy = bus.in_stg_rdy[k];
      end
    end
    kmin = rs_k;
    if (!rs_hit || (rt_hit && (rt_k < rs_k))) begin
      kmin = rt_k;
    end
    extra = CNT_W'(NSTG - 1) - CNT_W'(kmin);
  end

  always_comb begin
    stall   = 1'b0;
    bubble  = 1'b0;
    fwd_rs  = '0;
    fwd_rt  = '0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_rst) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end else if (bus.in_flush) begin
      bubble  = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (FWD_EN == 0) begin
            if (rs_hit || rt_hit) begin
              stall  = 1'b1;
              bubble = 1'b1;
              // Stall until the youngest conflicting writer has retired past the last stage.
              if (extra != '0) begin
                state_d = STALL;
                cnt_d   = extra;
              end
            end
          end else begin
            if (rs_hit) begin
              if (rs_rdy) fwd_rs = rs_k + FWD_W'(1);
              else        stall  = 1'b1;
            end
            if (rt_hit) begin
              if (rt_rdy) fwd_rt = rt_k + FWD_W'(1);
              else        stall  = 1'b1;
            end
            bubble = stall;
          end
        end
        STALL: begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = IDLE;
        end
      endcase
    end

    total_d = total_q;
    if (stall && (total_q != '1)) begin
      total_d = total_q + STAT_W'(1);
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
    end
  end

  assign bus.out_stall       = stall;
  assign bus.out_bubble      = bubble;
  assign bus.out_fwd_rs      = fwd_rs;
  assign bus.out_fwd_rt      = fwd_rt;
  assign bus.out_stall_cnt   = cnt_q;
  assign bus.out_stall_total = total_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a stall-only instance and a forwarding instance share stimulus
// and are checked every cycle against a rule-level model, plus directed literal checks.
module tb_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int NSTG   = 3;
  localparam int CNT_W  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs_addr, rt_addr;
  logic        rs_rena, rt_rena;
  logic [2:0]  wena, rdy;
  logic [14:0] waddr;
  logic        flush;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(REG_AW), .NSTG(NSTG), .CNT_W(CNT_W), .STAT_W(16)) bus0 ();
  hazard_ctrl_if #(.REG_AW(REG_AW), .NSTG(NSTG), .CNT_W(CNT_W), .STAT_W(4))  bus1 ();

  assign bus0.in_rs_addr = rs_addr;  assign bus1.in_rs_addr = rs_addr;
  assign bus0.in_rt_addr = rt_addr;  assign bus1.in_rt_addr = rt_addr;
  assign bus0.in_rs_rena = rs_rena;  assign bus1.in_rs_rena = rs_rena;
  assign bus0.in_rt_rena = rt_rena;  assign bus1.in_rt_rena = rt_rena;
  assign bus0.in_stg_wena = wena;    assign bus1.in_stg_wena = wena;
  assign bus0.in_stg_waddr = waddr;  assign bus1.in_stg_waddr = waddr;
  assign bus0.in_stg_rdy = rdy;      assign bus1.in_stg_rdy = rdy;
  assign bus0.in_flush = flush;      assign bus1.in_flush = flush;

  hazard_ctrl #(.REG_AW(REG_AW), .NSTG(NSTG), .FWD_EN(0), .CNT_W(CNT_W), .STAT_W(16)) dut0 (
    .in_clk(clk), .in_rst(rst), .bus(bus0)
  );
  hazard_ctrl #(.REG_AW(REG_AW), .NSTG(NSTG), .FWD_EN(1), .CNT_W(CNT_W), .STAT_W(4)) dut1 (
    .in_clk(clk), .in_rst(rst), .bus(bus1)
  );

  // Model state per instance: post-reset hold pending, remaining forced stall cycles, statistic.
  bit m_hold[2]  = '{1'b1, 1'b1};
  int m_left[2]  = '{0, 0};
  int m_total[2] = '{0, 0};
  bit n_hold[2]  = '{1'b1, 1'b1};
  int n_left[2]  = '{0, 0};
  int n_total[2] = '{0, 0};
  int m_max[2]   = '{65535, 15};

  function automatic int hitStage(input logic [4:0] a, input logic en,
                                  input logic [2:0] we, input logic [14:0] wa);
    if (!en || (a == 5'd0)) return -1;
    for (int k = 0; k < NSTG; k++) begin
      if (we[k] && (wa[k*REG_AW +: REG_AW] == a)) return k;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dutOut(input int m, input int which);
    if (m == 0) begin
      case (which)
        0: return 32'(bus0.out_stall);
        1: return 32'(bus0.out_bubble);
        2: return 32'(bus0.out_fwd_rs);
        3: return 32'(bus0.out_fwd_rt);
        4: return 32'(bus0.out_stall_cnt);
        default: return 32'(bus0.out_stall_total);
      endcase
    end
    case (which)
      0: return 32'(bus1.out_stall);
      1: return 32'(bus1.out_bubble);
      2: return 32'(bus1.out_fwd_rs);
      3: return 32'(bus1.out_fwd_rt);
      4: return 32'(bus1.out_stall_cnt);
      default: return 32'(bus1.out_stall_total);
    endcase
  endfunction

  // Every cycle: predict outputs from the hazard rules, compare, and stage the next model state.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int hr, ht, kmin, e_rs, e_rt, e_cnt, e_total;
      bit e_stall, e_bubble;
      e_rs = 0; e_rt = 0; e_stall = 1'b0; e_bubble = 1'b0;
      e_cnt = m_left[m]; e_total = m_total[m];
      n_hold[m] = m_hold[m];
      n_left[m] = m_left[m];
      if (rst) begin
        e_stall = 1'b1; e_bubble = 1'b1; e_cnt = 0; e_total = 0;
        n_hold[m] = 1'b1; n_left[m] = 0;
      end else if (flush) begin
        e_bubble = 1'b1; n_hold[m] = 1'b0; n_left[m] = 0;
      end else if (m_hold[m]) begin
        e_stall = 1'b1; e_bubble = 1'b1; n_hold[m] = 1'b0;
      end else if (m_left[m] > 0) begin
        e_stall = 1'b1; e_bubble = 1'b1; n_left[m] = m_left[m] - 1;
      end else begin
        hr = hitStage(rs_addr, rs_rena, wena, waddr);
        ht = hitStage(rt_addr, rt_rena, wena, waddr);
        if (m == 0) begin
          if (hr >= 0 || ht >= 0) begin
            kmin = (hr < 0) ? ht : ((ht < 0) ? hr : ((hr < ht) ? hr : ht));
            e_stall = 1'b1; e_bubble = 1'b1;
            n_left[m] = NSTG - kmin - 1;
          end
        end else begin
          if (hr >= 0) begin
            if (rdy[hr]) e_rs = hr + 1; else e_stall = 1'b1;
          end
          if (ht >= 0) begin
            if (rdy[ht]) e_rt = ht + 1; else e_stall = 1'b1;
          end
          e_bubble = e_stall;
        end
      end
      if (rst) n_total[m] = 0;
      else if (e_stall) n_total[m] = (m_total[m] + 1 > m_max[m]) ? m_max[m] : m_total[m] + 1;
      else n_total[m] = m_total[m];

      checkOutput($sformatf("dut%0d stall", m), dutOut(m, 0), 32'(e_stall));
      checkOutput($sformatf("dut%0d bubble", m), dutOut(m, 1), 32'(e_bubble));
      checkOutput($sformatf("dut%0d cnt", m), dutOut(m, 4), 32'(e_cnt));
      checkOutput($sformatf("dut%0d total", m), dutOut(m, 5), 32'(e_total));
      if (rst || !flush) begin
        checkOutput($sformatf("dut%0d fwd_rs", m), dutOut(m, 2), 32'(e_rs));
        checkOutput($sformatf("dut%0d fwd_rt", m), dutOut(m, 3), 32'(e_rt));
      end
    end
  end

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      m_hold[m]  = n_hold[m];
      m_left[m]  = n_left[m];
      m_total[m] = n_total[m];
    end
  end

  task automatic applyStimulus(input logic [4:0] rs, input logic rse, input logic [4:0] rt,
                               input logic rte, input logic [2:0] we, input logic [4:0] w0,
                               input logic [4:0] w1, input logic [4:0] w2,
                               input logic [2:0] rd, input logic fl);
    @(posedge clk);
    #1;
    rs_addr = rs; rs_rena = rse; rt_addr = rt; rt_rena = rte;
    wena = we; waddr = {w2, w1, w0}; rdy = rd; flush = fl;
  endtask

  task automatic idleCycle();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 3'b111, 1'b0);
  endtask

  task automatic sampleCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic expectStall(input int m, input string tag, input int st, input int bu,
                             input int cnt, input int tot);
    checkOutput({tag, " stall"}, dutOut(m, 0), 32'(st));
    checkOutput({tag, " bubble"}, dutOut(m, 1), 32'(bu));
    checkOutput({tag, " cnt"}, dutOut(m, 4), 32'(cnt));
    if (tot >= 0) checkOutput({tag, " total"}, dutOut(m, 5), 32'(tot));
  endtask

  task automatic expectFwd(input int m, input string tag, input int frs, input int frt, input int st);
    checkOutput({tag, " fwd_rs"}, dutOut(m, 2), 32'(frs));
    checkOutput({tag, " fwd_rt"}, dutOut(m, 3), 32'(frt));
    checkOutput({tag, " stall"}, dutOut(m, 0), 32'(st));
  endtask

  initial begin
    rs_addr = '0; rt_addr = '0; rs_rena = 1'b0; rt_rena = 1'b0;
    wena = '0; waddr = '0; rdy = 3'b111; flush = 1'b0;

    repeat (2) @(posedge clk);
    sampleCycle();
    expectStall(0, "reset", 1, 1, 0, 0);
    expectFwd(0, "reset", 0, 0, 1);

    @(posedge clk); #1 rst = 1'b0;
    sampleCycle();
    expectStall(0, "hold", 1, 1, 0, 0);
    idleCycle(); sampleCycle();
    expectStall(0, "after hold", 0, 0, 0, 1);
    expectStall(1, "after hold dut1", 0, 0, 0, 1);

    // EX writes r5, rs reads r5.
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 3'b111, 1'b0);
    sampleCycle();
    expectStall(0, "ex hz c1", 1, 1, 0, 1);
    expectFwd(1, "ex fwd", 1, 0, 0);
    idleCycle(); sampleCycle(); expectStall(0, "ex hz c2", 1, 1, 2, 2);
    idleCycle(); sampleCycle(); expectStall(0, "ex hz c3", 1, 1, 1, 3);
    idleCycle(); sampleCycle(); expectStall(0, "ex hz done", 0, 0, 0, 4);

    // MEM writes r5, WB writes r7.
    applyStimulus(5'd5, 1'b1, 5'd7, 1'b1, 3'b110, 5'd0, 5'd5, 5'd7, 3'b111, 1'b0);
    sampleCycle();
    expectStall(0, "mem hz c1", 1, 1, 0, 4);
    expectFwd(1, "mem/wb fwd", 2, 3, 0);
    idleCycle(); sampleCycle(); expectStall(0, "mem hz c2", 1, 1, 1, 5);
    idleCycle(); sampleCycle(); expectStall(0, "mem hz done", 0, 0, 0, 6);

    applyStimulus(5'd0, 1'b1, 5'd0, 1'b0, 3'b001, 5'd0, 5'd0, 5'd0, 3'b111, 1'b0);
    sampleCycle();
    expectStall(0, "r0 no hz", 0, 0, 0, 6);
    expectFwd(1, "r0 no fwd", 0, 0, 0);

    applyStimulus(5'd0, 1'b0, 5'd8, 1'b1, 3'b001, 5'd8, 5'd0, 5'd0, 3'b111, 1'b0);
    sampleCycle(); expectFwd(1, "fwd rt ex", 0, 1, 0);
    applyStimulus(5'd0, 1'b0, 5'd8, 1'b1, 3'b011, 5'd8, 5'd8, 5'd0, 3'b111, 1'b0);
    sampleCycle(); expectFwd(1, "youngest wins", 0, 1, 0);

    // Load in EX, then the same load in MEM with data ready.
    applyStimulus(5'd9, 1'b1, 5'd0, 1'b0, 3'b001, 5'd9, 5'd0, 5'd0, 3'b110, 1'b0);
    sampleCycle(); expectFwd(1, "load use", 0, 0, 1);
    applyStimulus(5'd9, 1'b1, 5'd0, 1'b0, 3'b010, 5'd0, 5'd9, 5'd0, 3'b111, 1'b0);
    sampleCycle(); expectFwd(1, "load fwd mem", 2, 0, 0);

    repeat (4) idleCycle();
    sampleCycle(); expectStall(0, "quiet", 0, 0, 0, -1);

    // Flush during a stall.
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 3'b111, 1'b0);
    sampleCycle(); expectStall(0, "flush pre", 1, 1, 0, -1);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 3'b111, 1'b1);
    sampleCycle(); expectStall(0, "flush cyc", 0, 1, 2, -1);
    idleCycle(); sampleCycle(); expectStall(0, "flush after", 0, 0, 0, -1);

    // Reset in the middle of a stall.
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 3'b111, 1'b0);
    idleCycle(); sampleCycle(); expectStall(0, "pre abort", 1, 1, 2, -1);
    @(posedge clk); #1 rst = 1'b1;
    sampleCycle(); expectStall(0, "abort", 1, 1, 0, 0);
    @(posedge clk); #1 rst = 1'b0;
    sampleCycle(); expectStall(0, "abort hold", 1, 1, 0, 0);
    idleCycle(); sampleCycle(); expectStall(0, "abort done", 0, 0, 0, 1);

    // Saturate the 4-bit statistic of the forwarding instance with load-use stalls.
    repeat (20) applyStimulus(5'd9, 1'b1, 5'd0, 1'b0, 3'b001, 5'd9, 5'd0, 5'd0, 3'b110, 1'b0);
    sampleCycle(); expectStall(1, "saturate", 1, 1, 0, 15);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rs_addr = 5'($urandom_range(0, 3));
      rt_addr = 5'($urandom_range(0, 3));
      rs_rena = 1'($urandom_range(0, 1));
      rt_rena = 1'($urandom_range(0, 1));
      wena    = 3'($urandom_range(0, 7));
      waddr   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rdy     = 3'($urandom_range(0, 7));
      flush   = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    idleCycle();
    sampleCycle();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
